demon_timer_bank: RTL and testbench
===================================

Name: demon_timer_bank

Overview:
- Parametrised, multi-channel successor to the single fixed MAX_COUNT timer.
- A shared prescaler divides clk by MAX_COUNT to produce a tick.
- NUM_CH independent channels each count a programmable number of ticks, in one-shot or periodic mode, with pulse or toggle output.
- Sits between the top-level pin mapping and the demon state logic; channel outputs drive LEDs/events.

Parameters:
- MAX_COUNT, 10_000_000: prescaler divide ratio, clk cycles per tick; legal values are ≥1.
- NUM_CH, 4: number of channels, ≥1.
- CNT_W, 8: width of the per-channel period and down-counter.
- CH_W, $clog2(NUM_CH) (min 1): width of the channel select.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ena  in  1  prescaler enable; low freezes the prescaler.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  CH_W  channel addressed by cfg_we.
- cfg_period  in  CNT_W  ticks per expiry.
- cfg_mode  in  2  bit0 = periodic (1) / one-shot (0); bit1 = toggle (1) / pulse (0).
- start  in  NUM_CH  per-channel start/restart strobe.
- stop  in  NUM_CH  per-channel stop strobe.
- tick  out  1  registered prescaler tick, one clk wide.
- ch_out  out  NUM_CH  channel outputs, registered.
- ch_busy  out  NUM_CH  channel in RUN.
- ch_done  out  NUM_CH  sticky one-shot completion flag.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port reset. When reset is high at a clk edge, all state clears:
  - prescaler = 0, tick = 0;
  - every period = 0, mode = 0, cnt = 0, state = IDLE;
  - ch_out = 0, ch_busy = 0, ch_done = 0.
  - Reset mid-count aborts with no expiry event.
- Prescaler:
  - pcnt counts 0..MAX_COUNT-1 while ena = 1.
  - When pcnt == MAX_COUNT-1 and ena = 1: pcnt wraps to 0 and tick = 1 on the next cycle; otherwise tick = 0.
  - MAX_COUNT = 1 gives tick = 1 on every cycle after an enabled cycle.
  - ena = 0 holds pcnt and produces no ticks. start, stop and cfg still act.
- Channels use the registered tick; prescaler wrap to channel decrement is 1 cycle.
- Config:
  - cfg_we writes period/mode of channel cfg_ch.
  - cfg_ch ≥ NUM_CH is ignored.
  - Writes during RUN take effect at the next load/reload; an in-progress cnt is untouched. Mode applies immediately.
- Per-channel FSM, states IDLE and RUN. Priority per cycle: stop > start > tick.
  - stop[i]: go to IDLE, no expiry. Pulse mode: ch_out = 0. Toggle mode: ch_out holds. ch_done is unchanged.
  - start[i] with period ≠ 0: cnt ← period, go to RUN, ch_done ← 0. Valid from IDLE or RUN; in RUN it restarts.
  - start[i] with period == 0: ignored, state unchanged.
  - tick in RUN with cnt > 1: cnt ← cnt-1.
  - tick in RUN with cnt == 1: expiry.
    - Periodic: cnt ← period (period 0 written meanwhile: go to IDLE instead, no done).
    - One-shot: go to IDLE, ch_done ← 1.
- Expiry output, registered, visible the cycle after the expiring tick:
  - Pulse mode: ch_out high exactly 1 clk.
  - Toggle mode: ch_out inverts.
- ch_busy = (state == RUN), registered with the state.
- Period P therefore expires on the P-th tick after start. Periodic expiries are P ticks apart.
- Channels are fully independent; simultaneous starts, expiries and stops on different channels all take effect.

Test Plan:
1. MAX_COUNT=4, ena=1 held after reset → tick high 1 cycle every 4 clk. First tick 4 cycles after reset release. pcnt frozen while ena=0.
2. ch0: period=3, one-shot, pulse; start → ch_busy=1. ch_out pulses once on the cycle after the 3rd tick; ch_busy=0; ch_done=1. ch_done stays set until the next start.
3. ch1: period=2, periodic, toggle → ch_out toggles every 2 ticks (0→1→0→1). A cfg write of period=5 mid-run takes effect only after the next reload.
4. ch2 running, stop and start asserted in the same cycle → IDLE, ch_busy=0, no expiry. start with period=0 → no state change.
5. NUM_CH=4: all channels started together with periods 1,2,3,4 → ch_out pulses on ticks 1,2,3,4 respectively. cfg_ch out of range (NUM_CH=3, cfg_ch=3) → no register changes.
6. reset asserted mid-count on all channels → next cycle all outputs 0, state IDLE, periods 0. A subsequent start is ignored until reconfigured.

Source files
------------

// File: rtl/demon_timer_bank.sv
// Multi-channel tick timer: a shared prescaler turns clk into a tick, and each
// channel counts a programmable number of ticks in one-shot or periodic mode.
module demon_timer_bank #(
    parameter int MAX_COUNT = 10_000_000,
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 8,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ena,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [1:0]        cfg_mode,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] stop,
    output logic              tick,
    output logic [NUM_CH-1:0] ch_out,
    output logic [NUM_CH-1:0] ch_busy,
    output logic [NUM_CH-1:0] ch_done
);

    localparam int            PW    = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
    localparam logic [PW-1:0] PLAST = PW'(MAX_COUNT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [PW-1:0] pcnt;

    state_t           state     [NUM_CH];
    state_t           state_nxt [NUM_CH];
    logic [CNT_W-1:0] cnt       [NUM_CH];
    logic [CNT_W-1:0] cnt_nxt   [NUM_CH];
    logic [CNT_W-1:0] period    [NUM_CH];
    logic [1:0]       mode      [NUM_CH];

    logic [NUM_CH-1:0] done_nxt;
    logic [NUM_CH-1:0] out_nxt;
    logic [NUM_CH-1:0] expire;

    // Prescaler: tick is registered, so channels see it one cycle after the wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (ena) begin
                if (pcnt == PLAST) begin
                    pcnt <= '0;
                    tick <= 1'b1;
                end else begin
                    pcnt <= pcnt + PW'(1);
                end
            end
        end
    end

    // Channel state register, config registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i]  <= IDLE;
                cnt[i]    <= '0;
                period[i] <= '0;
                mode[i]   <= 2'b00;
            end
            ch_out  <= '0;
            ch_done <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
                // Out-of-range addresses match no channel and are dropped
                if (cfg_we && (cfg_ch == CH_W'(i))) begin
                    period[i] <= cfg_period;
                    mode[i]   <= cfg_mode;
                end
            end
            ch_out  <= out_nxt;
            ch_done <= done_nxt;
        end
    end

    // Next-state logic, priority stop > start > tick
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            done_nxt[i]  = ch_done[i];
            expire[i]    = 1'b0;
            if (stop[i]) begin
                state_nxt[i] = IDLE;
            end else if (start[i] && (period[i] != '0)) begin
                cnt_nxt[i]   = period[i];
                state_nxt[i] = RUN;
                done_nxt[i]  = 1'b0;
            end else if (tick && (state[i] == RUN)) begin
                if (cnt[i] > CNT_W'(1)) begin
                    cnt_nxt[i] = cnt[i] - CNT_W'(1);
                end else begin
                    expire[i] = 1'b1;
                    if (mode[i][0] && (period[i] != '0)) begin
                        cnt_nxt[i] = period[i];
                    end else begin
                        // One-shot finishes; periodic with a zeroed period just stops
                        state_nxt[i] = IDLE;
                        if (!mode[i][0]) begin
                            done_nxt[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Output decode: pulse mode follows the expiry, toggle mode flips on it
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            out_nxt[i] = mode[i][1] ? (ch_out[i] ^ expire[i]) : expire[i];
            ch_busy[i] = (state[i] == RUN);
        end
    end

endmodule

// File: tb/tb_demon_timer_bank.sv
// Directed bench for demon_timer_bank; expectations are queued as stimulus is
// driven and compared by a negedge monitor.
module tb_demon_timer_bank;

    logic       clk = 1'b0;
    logic       reset, ena, cfg_we, cfg_we3;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_period;
    logic [1:0] cfg_mode;
    logic [3:0] start, stop;
    logic [2:0] start3, stop3;
    logic       tick, tick3;
    logic [3:0] ch_out, ch_busy, ch_done;
    logic [2:0] out3, busy3, done3;

    demon_timer_bank #(.MAX_COUNT(4), .NUM_CH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .ena(ena), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_mode(cfg_mode), .start(start), .stop(stop),
        .tick(tick), .ch_out(ch_out), .ch_busy(ch_busy), .ch_done(ch_done)
    );

    demon_timer_bank #(.MAX_COUNT(4), .NUM_CH(3), .CNT_W(8)) dut3 (
        .clk(clk), .reset(reset), .ena(ena), .cfg_we(cfg_we3), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_mode(cfg_mode), .start(start3), .stop(stop3),
        .tick(tick3), .ch_out(out3), .ch_busy(busy3), .ch_done(done3)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        int         sel;
        int         ch;
        logic [3:0] exp;
        int         at;
    } sb_entry_t;

    sb_entry_t  sb[$];
    sb_entry_t  e;
    logic [3:0] obs;
    int         cyc = 0;
    int         ph = 0;
    int         checks = 0;
    int         failures = 0;
    logic [3:0] eo, eb;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] sample(int sel, int ch);
        case (sel)
            0: return {3'b000, tick};
            1: return {3'b000, ch_out[ch]};
            2: return {3'b000, ch_busy[ch]};
            3: return {3'b000, ch_done[ch]};
            4: return {1'b0, busy3};
            5: return ch_out;
            6: return ch_busy;
            7: return ch_done;
            default: return 4'bxxxx;
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e   = sb.pop_front();
            obs = sample(e.sel, e.ch);
            checks++;
            assert ((e.at == cyc) && (obs === e.exp)) else begin
                failures++;
                $error("FAIL %s cyc=%0d observed=%b expected=%b", e.tag, cyc, obs, e.exp);
            end
        end
    end

    task automatic chk(string tag, int sel, int ch, logic [3:0] exp);
        sb.push_back('{tag, sel, ch, exp, cyc});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ph = (ph + 1) % 4;
    endtask

    task automatic go_ph(int n);
        while (ph != n) step();
    endtask

    task automatic cfg_write(int ch, int per, int md);
        cfg_we     = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_period = 8'(per);
        cfg_mode   = 2'(md);
        step();
        cfg_we     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ena = 1'b0; cfg_we = 1'b0; cfg_we3 = 1'b0;
        cfg_ch = '0; cfg_period = '0; cfg_mode = '0;
        start = '0; stop = '0; start3 = '0; stop3 = '0;
        repeat (3) step();
        chk("rst_tick", 0, 0, 4'h0);
        chk("rst_out", 5, 0, 4'h0);
        chk("rst_busy", 6, 0, 4'h0);
        chk("rst_done", 7, 0, 4'h0);

        // Prescaler cadence, freeze and resume
        reset = 1'b0; ena = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("t1_tick", 0, 0, {3'b000, (k % 4) == 3});
        end
        ena = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t1_frozen", 0, 0, 4'h0);
        end
        ena = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t1_resume", 0, 0, {3'b000, k == 3});
        end
        ph = 0;

        // One-shot pulse, period 3
        cfg_write(0, 3, 0);
        go_ph(1);
        start = 4'b0001; step(); start = '0;
        chk("t2_busy0", 2, 0, 4'h1);
        chk("t2_done0", 3, 0, 4'h0);
        for (int k = 1; k <= 11; k++) begin
            step();
            chk("t2_out", 1, 0, {3'b000, k == 11});
            chk("t2_busy", 2, 0, {3'b000, k < 11});
            chk("t2_done", 3, 0, {3'b000, k >= 11});
        end
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_sticky", 3, 0, 4'h1);
            chk("t2_nopulse", 1, 0, 4'h0);
        end
        start = 4'b0001; step(); start = '0;
        chk("t2_restart_done", 3, 0, 4'h0);
        chk("t2_restart_busy", 2, 0, 4'h1);
        stop = 4'b0001; step(); stop = '0;
        chk("t2_stop_busy", 2, 0, 4'h0);

        // Periodic toggle with a mid-run period change
        cfg_write(1, 2, 3);
        go_ph(1);
        start = 4'b0010; step(); start = '0;
        chk("t3_busy1", 2, 1, 4'h1);
        for (int k = 1; k <= 36; k++) begin
            if (k == 8) begin
                cfg_we = 1'b1; cfg_ch = 2'd1; cfg_period = 8'd5; cfg_mode = 2'd3;
            end
            if (k == 9) cfg_we = 1'b0;
            step();
            chk("t3_out", 1, 1, {3'b000, ((k >= 7) && (k < 15)) || (k >= 35)});
            chk("t3_busy", 2, 1, 4'h1);
        end
        stop = 4'b0010; step(); stop = '0;
        chk("t3_stop_hold", 1, 1, 4'h1);
        chk("t3_stop_busy", 2, 1, 4'h0);

        // Stop wins over start; start with period 0 is ignored
        cfg_write(2, 4, 0);
        go_ph(1);
        start = 4'b0100; step(); start = '0;
        chk("t4_busy2", 2, 2, 4'h1);
        step(); step();
        stop = 4'b0100; start = 4'b0100; step(); stop = '0; start = '0;
        chk("t4_stop_busy", 2, 2, 4'h0);
        chk("t4_stop_done", 3, 2, 4'h0);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("t4_no_expiry", 1, 2, 4'h0);
            chk("t4_idle", 2, 2, 4'h0);
        end
        cfg_write(2, 0, 0);
        start = 4'b0100; step(); start = '0;
        chk("t4_zero_busy", 2, 2, 4'h0);
        chk("t4_zero_done", 3, 2, 4'h0);

        // All channels together, periods 1..4
        for (int i = 0; i < 4; i++) cfg_write(i, i + 1, 0);
        go_ph(1);
        start = 4'hF; step(); start = '0;
        chk("t5_busy_all", 6, 0, 4'hF);
        chk("t5_out_none", 5, 0, 4'h0);
        for (int k = 1; k <= 16; k++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                eo[i] = (k == 3 + 4 * i);
                eb[i] = (k < 3 + 4 * i);
            end
            chk("t5_out", 5, 0, eo);
            chk("t5_busy", 6, 0, eb);
        end
        chk("t5_done_all", 7, 0, 4'hF);

        // Out-of-range address on a three-channel bank
        cfg_we3 = 1'b1; cfg_ch = 2'd3; cfg_period = 8'd1; cfg_mode = 2'd0;
        step(); cfg_we3 = 1'b0;
        start3 = 3'b111; step(); start3 = '0;
        chk("t5_oor_busy", 4, 0, 4'h0);
        step();
        chk("t5_oor_busy2", 4, 0, 4'h0);
        cfg_we3 = 1'b1; cfg_ch = 2'd2; cfg_period = 8'd1;
        step(); cfg_we3 = 1'b0;
        start3 = 3'b111; step(); start3 = '0;
        chk("t5_inrange_busy", 4, 0, 4'b0100);

        // Reset mid-count clears everything including periods
        for (int i = 0; i < 4; i++) cfg_write(i, 10, 1);
        start = 4'hF; step(); start = '0;
        repeat (5) step();
        chk("t6_running", 6, 0, 4'hF);
        reset = 1'b1; step(); reset = 1'b0;
        chk("t6_tick", 0, 0, 4'h0);
        chk("t6_out", 5, 0, 4'h0);
        chk("t6_busy", 6, 0, 4'h0);
        chk("t6_done", 7, 0, 4'h0);
        start = 4'hF; step(); start = '0;
        chk("t6_start_ignored", 6, 0, 4'h0);
        step();
        chk("t6_still_idle", 6, 0, 4'h0);
        cfg_write(0, 2, 0);
        start = 4'b0001; step(); start = '0;
        chk("t6_reconfig_busy", 6, 0, 4'b0001);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            failures += sb.size();
            $display("FAIL sb_drain observed=%0d pending expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
